// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port dmem: CPU has priority, and a DMA request is forced through after STARVE_LIMIT waiting cycles.
// Grants are combinational; read data returns one cycle after the grant and is steered to the side that issued the read.
module dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DMA  = 2'd2
  } rd_owner_e;

  localparam int WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  rd_owner_e         rd_owner_q, rd_owner_d;
  logic [WAIT_W-1:0] dma_wait_q, dma_wait_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic force_dma;
  logic dma_gnt_w;
  logic cpu_gnt_w;

  // The reset input gates the grants directly, so nothing reaches dmem while reset is held.
  always_comb begin
    force_dma = dma_req & (dma_wait_q == WAIT_MAX);
    dma_gnt_w = reset & dma_req & (~cpu_req | force_dma);
    cpu_gnt_w = reset & cpu_req & ~dma_gnt_w;
  end

  assign dma_gnt   = dma_gnt_w;
  assign cpu_stall = cpu_req & ~cpu_gnt_w;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (cpu_gnt_w) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wren  = cpu_we;
    end else if (dma_gnt_w) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_wren  = dma_we;
    end
  end

  always_comb begin
    dma_wait_d = dma_wait_q;
    if (~dma_req || dma_gnt_w) begin
      dma_wait_d = '0;
    end else if (dma_wait_q != WAIT_MAX) begin
      dma_wait_d = dma_wait_q + 1'b1;
    end
  end

  // Read-return owner: each cycle depends only on that cycle's grant.
  always_comb begin
    rd_owner_d  = RD_NONE;
    cpu_rvalid  = 1'b0;
    dma_rvalid  = 1'b0;
    cpu_rdata   = cpu_rdata_q;
    dma_rdata   = dma_rdata_q;

    if (cpu_gnt_w && !cpu_we) begin
      rd_owner_d = RD_CPU;
    end else if (dma_gnt_w && !dma_we) begin
      rd_owner_d = RD_DMA;
    end

    case (rd_owner_q)
      RD_CPU: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = mem_q;
      end
      RD_DMA: begin
        dma_rvalid = 1'b1;
        dma_rdata  = mem_q;
      end
      default: ;
    endcase

    cpu_rdata_d = cpu_rdata;
    dma_rdata_d = dma_rdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_owner_q  <= RD_NONE;
      dma_wait_q  <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      dma_wait_q  <= dma_wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

endmodule
